// File: rtl/uart_pkg.sv
// Shared definitions for the UART: parity modes, FSM state encodings and
// the clocks-per-bit rounding helper.
package uart_pkg;

    localparam int PAR_NONE = 0;
    localparam int PAR_EVEN = 1;
    localparam int PAR_ODD  = 2;

    typedef enum logic [2:0] {
        TX_IDLE,
        TX_START,
        TX_DATA,
        TX_PARITY,
        TX_STOP
    } tx_state_e;

    typedef enum logic [2:0] {
        RX_IDLE,
        RX_START,
        RX_DATA,
        RX_PARITY,
        RX_STOP
    } rx_state_e;

    // Nearest-integer clocks per bit.
    function automatic int calc_div(input int clk_freq, input int baud_rate);
        return (clk_freq + baud_rate / 2) / baud_rate;
    endfunction

    function automatic logic calc_parity(input logic [7:0] data, input int mode);
        return (mode == PAR_ODD) ? ~(^data) : ^data;
    endfunction

endpackage

// File: rtl/uart_bit_timer.sv
// Bit-period counter: start_i loads a full or half period, and while enabled
// the counter free-runs, asserting tick_o on the last cycle of each period.
module uart_bit_timer #(
    parameter int DIV = 32
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic start_i,
    input  logic half_i,
    input  logic en_i,
    output logic tick_o
);

    localparam int W = $clog2(DIV);
    localparam logic [W-1:0] FULL_RELOAD = W'(DIV - 1);
    localparam logic [W-1:0] HALF_RELOAD = W'(DIV / 2 - 1);

    logic [W-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (start_i) begin
            cnt_d = half_i ? HALF_RELOAD : FULL_RELOAD;
        end else if (en_i) begin
            cnt_d = (cnt_q == '0) ? FULL_RELOAD : cnt_q - W'(1);
        end
    end

    // Not gated by start_i: the TX FSM derives start_i from this tick.
    assign tick_o = en_i && (cnt_q == '0);

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/uart.sv
// Full-duplex 8N1 / 8E1 / 8O1 UART with independent TX and RX state machines
// sharing one clock; RX input is double-flopped before use.
module uart
    import uart_pkg::*;
#(
    parameter int CLK_FREQ   = 3684000,
    parameter int BAUD_RATE  = 115200,
    parameter int PARITY_BIT = 0
) (
    input  logic       CLK,
    input  logic       RST,
    input  logic       UART_RXD,
    input  logic       DATA_SEND,
    input  logic [7:0] DATA_IN,
    output logic       UART_TXD,
    output logic       BUSY,
    output logic [7:0] DATA_OUT,
    output logic       DATA_VLD,
    output logic       FRAME_ERROR
);

    localparam int DIV    = calc_div(CLK_FREQ, BAUD_RATE);
    localparam bit PAR_EN = (PARITY_BIT != PAR_NONE);

    if (DIV < 4) begin : g_div_check
        $error("uart: CLK_FREQ/BAUD_RATE must round to at least 4");
    end

    // ---------------- transmitter ----------------
    tx_state_e  tx_state_q, tx_state_d;
    logic [7:0] tx_data_q, tx_data_d;
    logic [2:0] tx_bit_q, tx_bit_d;
    logic       tx_par_q, tx_par_d;
    logic       tx_txd_q, tx_txd_d;
    logic       tx_busy_q, tx_busy_d;
    logic       tx_timer_start;
    logic       tx_tick;

    uart_bit_timer #(.DIV(DIV)) u_tx_timer (
        .clk_i   (CLK),
        .rst_i   (RST),
        .start_i (tx_timer_start),
        .half_i  (1'b0),
        .en_i    (tx_state_q != TX_IDLE),
        .tick_o  (tx_tick)
    );

    always_comb begin
        tx_state_d     = tx_state_q;
        tx_data_d      = tx_data_q;
        tx_bit_d       = tx_bit_q;
        tx_par_d       = tx_par_q;
        tx_txd_d       = tx_txd_q;
        tx_busy_d      = tx_busy_q;
        tx_timer_start = 1'b0;
        case (tx_state_q)
            TX_IDLE: begin
                if (DATA_SEND) begin
                    tx_state_d     = TX_START;
                    tx_data_d      = DATA_IN;
                    tx_par_d       = calc_parity(DATA_IN, PARITY_BIT);
                    tx_txd_d       = 1'b0;
                    tx_busy_d      = 1'b1;
                    tx_timer_start = 1'b1;
                end
            end
            TX_START: begin
                if (tx_tick) begin
                    tx_state_d = TX_DATA;
                    tx_bit_d   = 3'd0;
                    tx_txd_d   = tx_data_q[0];
                end
            end
            TX_DATA: begin
                if (tx_tick) begin
                    if (tx_bit_q == 3'd7) begin
                        tx_state_d = PAR_EN ? TX_PARITY : TX_STOP;
                        tx_txd_d   = PAR_EN ? tx_par_q : 1'b1;
                    end else begin
                        tx_bit_d  = tx_bit_q + 3'd1;
                        tx_data_d = {1'b0, tx_data_q[7:1]};
                        tx_txd_d  = tx_data_q[1];
                    end
                end
            end
            TX_PARITY: begin
                if (tx_tick) begin
                    tx_state_d = TX_STOP;
                    tx_txd_d   = 1'b1;
                end
            end
            TX_STOP: begin
                if (tx_tick) begin
                    // A held request chains straight into the next start bit.
                    if (DATA_SEND) begin
                        tx_state_d     = TX_START;
                        tx_data_d      = DATA_IN;
                        tx_par_d       = calc_parity(DATA_IN, PARITY_BIT);
                        tx_txd_d       = 1'b0;
                        tx_timer_start = 1'b1;
                    end else begin
                        tx_state_d = TX_IDLE;
                        tx_txd_d   = 1'b1;
                        tx_busy_d  = 1'b0;
                    end
                end
            end
            default: begin
                tx_state_d = TX_IDLE;
                tx_txd_d   = 1'b1;
                tx_busy_d  = 1'b0;
            end
        endcase
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            tx_state_q <= TX_IDLE;
            tx_data_q  <= '0;
            tx_bit_q   <= '0;
            tx_par_q   <= 1'b0;
            tx_txd_q   <= 1'b1;
            tx_busy_q  <= 1'b0;
        end else begin
            tx_state_q <= tx_state_d;
            tx_data_q  <= tx_data_d;
            tx_bit_q   <= tx_bit_d;
            tx_par_q   <= tx_par_d;
            tx_txd_q   <= tx_txd_d;
            tx_busy_q  <= tx_busy_d;
        end
    end

    // ---------------- receiver ----------------
    // Synchroniser resets low so a line held low out of reset shows no edge.
    logic rx_meta_q, rx_sync_q, rx_prev_q;
    logic rx_fall;

    always_ff @(posedge CLK) begin
        if (RST) begin
            rx_meta_q <= 1'b0;
            rx_sync_q <= 1'b0;
            rx_prev_q <= 1'b0;
        end else begin
            rx_meta_q <= UART_RXD;
            rx_sync_q <= rx_meta_q;
            rx_prev_q <= rx_sync_q;
        end
    end

    assign rx_fall = rx_prev_q && !rx_sync_q;

    rx_state_e  rx_state_q, rx_state_d;
    logic [7:0] rx_data_q, rx_data_d;
    logic [2:0] rx_bit_q, rx_bit_d;
    logic       rx_par_ok_q, rx_par_ok_d;
    logic [7:0] rx_dout_q, rx_dout_d;
    logic       rx_vld_q, rx_vld_d;
    logic       rx_ferr_q, rx_ferr_d;
    logic       rx_timer_start;
    logic       rx_tick;

    uart_bit_timer #(.DIV(DIV)) u_rx_timer (
        .clk_i   (CLK),
        .rst_i   (RST),
        .start_i (rx_timer_start),
        .half_i  (1'b1),
        .en_i    (rx_state_q != RX_IDLE),
        .tick_o  (rx_tick)
    );

    always_comb begin
        rx_state_d     = rx_state_q;
        rx_data_d      = rx_data_q;
        rx_bit_d       = rx_bit_q;
        rx_par_ok_d    = rx_par_ok_q;
        rx_dout_d      = rx_dout_q;
        rx_vld_d       = 1'b0;
        rx_ferr_d      = 1'b0;
        rx_timer_start = 1'b0;
        case (rx_state_q)
            RX_IDLE: begin
                if (rx_fall) begin
                    rx_state_d     = RX_START;
                    rx_par_ok_d    = 1'b1;
                    rx_timer_start = 1'b1;
                end
            end
            RX_START: begin
                if (rx_tick) begin
                    rx_state_d = rx_sync_q ? RX_IDLE : RX_DATA;
                    rx_bit_d   = 3'd0;
                end
            end
            RX_DATA: begin
                if (rx_tick) begin
                    rx_data_d = {rx_sync_q, rx_data_q[7:1]};
                    if (rx_bit_q == 3'd7) begin
                        rx_state_d = PAR_EN ? RX_PARITY : RX_STOP;
                    end else begin
                        rx_bit_d = rx_bit_q + 3'd1;
                    end
                end
            end
            RX_PARITY: begin
                if (rx_tick) begin
                    rx_par_ok_d = (rx_sync_q == calc_parity(rx_data_q, PARITY_BIT));
                    rx_state_d  = RX_STOP;
                end
            end
            RX_STOP: begin
                if (rx_tick) begin
                    rx_state_d = RX_IDLE;
                    if (rx_sync_q && rx_par_ok_q) begin
                        rx_dout_d = rx_data_q;
                        rx_vld_d  = 1'b1;
                    end else begin
                        rx_ferr_d = 1'b1;
                    end
                end
            end
            default: rx_state_d = RX_IDLE;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            rx_state_q  <= RX_IDLE;
            rx_data_q   <= '0;
            rx_bit_q    <= '0;
            rx_par_ok_q <= 1'b1;
            rx_dout_q   <= '0;
            rx_vld_q    <= 1'b0;
            rx_ferr_q   <= 1'b0;
        end else begin
            rx_state_q  <= rx_state_d;
            rx_data_q   <= rx_data_d;
            rx_bit_q    <= rx_bit_d;
            rx_par_ok_q <= rx_par_ok_d;
            rx_dout_q   <= rx_dout_d;
            rx_vld_q    <= rx_vld_d;
            rx_ferr_q   <= rx_ferr_d;
        end
    end

    assign UART_TXD    = tx_txd_q;
    assign BUSY        = tx_busy_q;
    assign DATA_OUT    = rx_dout_q;
    assign DATA_VLD    = rx_vld_q;
    assign FRAME_ERROR = rx_ferr_q;

endmodule

// File: tb/tb_uart.sv
// Directed bench for uart: a no-parity instance and an even-parity instance,
// RX checked from a vector table, TX and corner cases by hand-written sequences.
module tb_uart;

    localparam int BIT = 32;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       rxd0 = 1'b0, rxd1 = 1'b1;
    logic       send0 = 1'b0, send1 = 1'b0;
    logic [7:0] din0 = 8'h00, din1 = 8'h00;
    logic       txd0, txd1, busy0, busy1, vld0, vld1, ferr0, ferr1;
    logic [7:0] dout0, dout1;

    always #5 clk = ~clk;

    uart dut (
        .CLK(clk), .RST(rst), .UART_RXD(rxd0), .DATA_SEND(send0), .DATA_IN(din0),
        .UART_TXD(txd0), .BUSY(busy0), .DATA_OUT(dout0), .DATA_VLD(vld0), .FRAME_ERROR(ferr0)
    );

    uart #(.PARITY_BIT(1)) dut_p (
        .CLK(clk), .RST(rst), .UART_RXD(rxd1), .DATA_SEND(send1), .DATA_IN(din1),
        .UART_TXD(txd1), .BUSY(busy1), .DATA_OUT(dout1), .DATA_VLD(vld1), .FRAME_ERROR(ferr1)
    );

    // Cycle counts of output pulses; a clean pulse contributes exactly one.
    int vld_hi0 = 0, ferr_hi0 = 0, vld_hi1 = 0, ferr_hi1 = 0;
    always @(posedge clk) begin
        if (vld0 === 1'b1)  vld_hi0++;
        if (ferr0 === 1'b1) ferr_hi0++;
        if (vld1 === 1'b1)  vld_hi1++;
        if (ferr1 === 1'b1) ferr_hi1++;
    end

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end else begin
            $display("ok   %s: %0h", name, act);
        end
    endtask

    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic drive_rx(input bit sel, input logic v);
        if (sel) rxd1 = v;
        else     rxd0 = v;
    endtask

    task automatic send_rx(input bit sel, input logic [7:0] d, input bit par_en,
                           input logic par_val, input logic stop_val);
        drive_rx(sel, 1'b0);
        step(BIT);
        for (int b = 0; b < 8; b++) begin
            drive_rx(sel, d[b]);
            step(BIT);
        end
        if (par_en) begin
            drive_rx(sel, par_val);
            step(BIT);
        end
        drive_rx(sel, stop_val);
        step(BIT);
        drive_rx(sel, 1'b1);
        step(40);
    endtask

    // Sends nframes frames of d by holding the request, perturbs DATA_IN
    // mid-frame, and checks every TXD cycle and the BUSY duration.
    task automatic tx_frame(input bit sel, input logic [7:0] d, input int nframes, input string name);
        int   len;
        int   bad [3];
        int   idle_bad;
        int   busy_cnt;
        int   k;
        logic exp_bit;
        logic cur_txd, cur_busy;
        len      = (sel ? 11 : 10) * BIT;
        bad      = '{0, 0, 0};
        idle_bad = 0;
        busy_cnt = 0;
        if (sel) begin din1 = d; send1 = 1'b1; end
        else     begin din0 = d; send0 = 1'b1; end
        step(1);
        for (int i = 0; i < nframes * len + 40; i++) begin
            if (i == (nframes - 1) * len + 10) begin
                if (sel) send1 = 1'b0; else send0 = 1'b0;
            end
            if (i == 1)       begin if (sel) din1 = ~d; else din0 = ~d; end
            if (i == len / 2) begin if (sel) din1 = d;  else din0 = d;  end
            cur_txd  = sel ? txd1 : txd0;
            cur_busy = sel ? busy1 : busy0;
            if (i == 0) check({name, " busy_first"}, {31'd0, cur_busy}, 32'd1);
            if (i < nframes * len) begin
                k = (i % len) / BIT;
                if (k == 0)                 exp_bit = 1'b0;
                else if (k <= 8)            exp_bit = d[k-1];
                else if (k == 9 && sel)     exp_bit = ^d;
                else                        exp_bit = 1'b1;
                if (cur_txd !== exp_bit) bad[i / len]++;
            end else if (cur_txd !== 1'b1) begin
                idle_bad++;
            end
            if (cur_busy === 1'b1) busy_cnt++;
            step(1);
        end
        for (int f = 0; f < nframes; f++)
            check($sformatf("%s frame%0d_bad_cycles", name, f), bad[f], 32'd0);
        check({name, " idle_bad_cycles"}, idle_bad, 32'd0);
        check({name, " busy_cycles"}, busy_cnt, nframes * len);
    endtask

    typedef struct {
        bit         sel;
        logic [7:0] data;
        bit         par_en;
        logic       par_val;
        logic       stop_val;
        int         exp_vld;
        int         exp_ferr;
        logic [7:0] exp_dout;
    } rx_vec_t;

    rx_vec_t vecs [7];

    initial begin
        int v0, f0, v1, f1;

        vecs[0] = '{0, 8'hA5, 0, 1'b0, 1'b1, 1, 0, 8'hA5};
        vecs[1] = '{0, 8'h3C, 0, 1'b0, 1'b0, 0, 1, 8'hA5};
        vecs[2] = '{0, 8'h00, 0, 1'b0, 1'b1, 1, 0, 8'h00};
        vecs[3] = '{0, 8'hFF, 0, 1'b0, 1'b1, 1, 0, 8'hFF};
        vecs[4] = '{1, 8'h01, 1, 1'b1, 1'b1, 1, 0, 8'h01};
        vecs[5] = '{1, 8'h01, 1, 1'b0, 1'b1, 0, 1, 8'h01};
        vecs[6] = '{1, 8'hA5, 1, 1'b0, 1'b1, 1, 0, 8'hA5};

        // Reset, with the RX line held low through and after it.
        step(5);
        check("rst txd",  {31'd0, txd0},  32'd1);
        check("rst busy", {31'd0, busy0}, 32'd0);
        check("rst vld",  {31'd0, vld0},  32'd0);
        check("rst ferr", {31'd0, ferr0}, 32'd0);
        check("rst dout", {24'd0, dout0}, 32'd0);
        rst = 1'b0;
        step(100);
        rxd0 = 1'b1;
        step(40);
        check("low_line vld",  vld_hi0,  32'd0);
        check("low_line ferr", ferr_hi0, 32'd0);

        tx_frame(0, 8'h33, 1, "tx_33");
        tx_frame(0, 8'h33, 2, "tx_held");
        tx_frame(1, 8'h01, 1, "tx_par");

        for (int i = 0; i < 7; i++) begin
            v0 = vld_hi0; f0 = ferr_hi0; v1 = vld_hi1; f1 = ferr_hi1;
            send_rx(vecs[i].sel, vecs[i].data, vecs[i].par_en, vecs[i].par_val, vecs[i].stop_val);
            if (vecs[i].sel) begin
                check($sformatf("rx%0d vld", i),  vld_hi1 - v1,  vecs[i].exp_vld);
                check($sformatf("rx%0d ferr", i), ferr_hi1 - f1, vecs[i].exp_ferr);
                check($sformatf("rx%0d dout", i), {24'd0, dout1}, {24'd0, vecs[i].exp_dout});
            end else begin
                check($sformatf("rx%0d vld", i),  vld_hi0 - v0,  vecs[i].exp_vld);
                check($sformatf("rx%0d ferr", i), ferr_hi0 - f0, vecs[i].exp_ferr);
                check($sformatf("rx%0d dout", i), {24'd0, dout0}, {24'd0, vecs[i].exp_dout});
            end
        end

        // 10-clock glitch on an idle line.
        v0 = vld_hi0; f0 = ferr_hi0;
        rxd0 = 1'b0;
        step(10);
        rxd0 = 1'b1;
        step(80);
        check("glitch vld",  vld_hi0 - v0,  32'd0);
        check("glitch ferr", ferr_hi0 - f0, 32'd0);

        // Reset while both directions are mid-frame.
        din0  = 8'h55;
        send0 = 1'b1;
        step(1);
        send0 = 1'b0;
        rxd0  = 1'b0;
        step(BIT);
        for (int b = 0; b < 4; b++) begin
            rxd0 = b[0];
            step(BIT);
        end
        v0 = vld_hi0; f0 = ferr_hi0;
        rst = 1'b1;
        step(1);
        check("midrst txd",  {31'd0, txd0},  32'd1);
        check("midrst busy", {31'd0, busy0}, 32'd0);
        step(2);
        rst  = 1'b0;
        rxd0 = 1'b1;
        check("midrst dout", {24'd0, dout0}, 32'd0);
        step(400);
        check("midrst vld",  vld_hi0 - v0,  32'd0);
        check("midrst ferr", ferr_hi0 - f0, 32'd0);
        check("midrst txd_idle", {31'd0, txd0}, 32'd1);
        v0 = vld_hi0; f0 = ferr_hi0;
        send_rx(0, 8'h5A, 0, 1'b0, 1'b1);
        check("post_rst rx vld",  vld_hi0 - v0,  32'd1);
        check("post_rst rx ferr", ferr_hi0 - f0, 32'd0);
        check("post_rst rx dout", {24'd0, dout0}, 32'h5A);
        tx_frame(0, 8'hC3, 1, "post_rst tx");

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
